// File: rtl/tlv5618_ctrl_if.sv
// Request and driver-side signals of the TLV5618 command sequencer.
// The slave modport is the sequencer's view. The master modport is the
// view of the surrounding logic: the request source and tlv5618_driver.
interface tlv5618_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [11:0] in_ch_a;
  logic [11:0] in_ch_b;
  logic [15:0] drv_set_data;
  logic        drv_set_go;
  logic        drv_set_done;
  logic        upd_done;
  logic        err_timeout;
  logic        busy;

  modport master (
    output in_valid, in_sel, in_ch_a, in_ch_b, drv_set_done,
    input  in_ready, drv_set_data, drv_set_go, upd_done, err_timeout, busy
  );

  modport slave (
    input  in_valid, in_sel, in_ch_a, in_ch_b, drv_set_done,
    output in_ready, drv_set_data, drv_set_go, upd_done, err_timeout, busy
  );
endinterface

// File: rtl/tlv5618_ctrl.sv
// tlv5618_ctrl: turns dual-channel 12-bit update requests into TLV5618
// control words {R1, SPD, PWR, R0, code}. Each word is issued to
// tlv5618_driver with a one-cycle go pulse. A chip-select idle gap of
// CS_GAP cycles follows every done pulse. A simultaneous A/B update is sent
// as two words: B to the buffer only, then A with a buffer-to-B load.
// Optional feature: define TLV5618_CTRL_TIMEOUT_EN to abort a request when
// the driver does not answer within TIMEOUT_CYCLES.
module tlv5618_ctrl #(
  parameter logic SPD            = 1'b1,
  parameter logic PWR            = 1'b0,
  parameter int   CS_GAP         = 4,
  parameter int   TIMEOUT_CYCLES = 1024
) (
  input logic           clk,
  input logic           rst_n,
  tlv5618_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, GAP = 2'd2} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  gap_cnt_reg, gap_cnt_next;
  logic        pend_reg, pend_next;        // second word of an A+B update outstanding
  logic [15:0] pend_word_reg, pend_word_next;
  logic        abort_reg, abort_next;      // request abandoned: suppress upd_done
  logic [15:0] data_reg, data_next;
  logic        go_reg, go_next;
  logic        done_reg, done_next;
  logic        ready_reg, ready_next;
`ifdef TLV5618_CTRL_TIMEOUT_EN
  logic [15:0] tmo_cnt_reg, tmo_cnt_next;
  logic        err_reg, err_next;
`endif

  // Reject parameter values outside their legal ranges at elaboration
  generate
    if (CS_GAP < 1 || CS_GAP > 255 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
      $error("tlv5618_ctrl: CS_GAP or TIMEOUT_CYCLES out of range");
    end
  endgenerate

  function automatic logic [15:0] mk_word(input logic [1:0] r, input logic [11:0] code);
    return {r[1], SPD, PWR, r[0], code};
  endfunction

  // Next-state and output decode for the IDLE / WAIT / GAP sequencer
  always_comb begin
    state_next     = state_reg;
    gap_cnt_next   = gap_cnt_reg;
    pend_next      = pend_reg;
    pend_word_next = pend_word_reg;
    abort_next     = abort_reg;
    data_next      = data_reg;
    go_next        = 1'b0;
    done_next      = 1'b0;
`ifdef TLV5618_CTRL_TIMEOUT_EN
    err_next       = 1'b0;
    tmo_cnt_next   = (state_reg == WAIT) ? tmo_cnt_reg + 16'd1 : 16'd0;
`endif
    case (state_reg)
      IDLE: begin
        // ready_reg lags IDLE by one cycle after GAP, so it gates acceptance
        if (bus.in_valid && ready_reg) begin
          abort_next = 1'b0;
          case (bus.in_sel)
            2'b01: begin  // A only: latch A, B reloaded from buffer (unchanged)
              data_next  = mk_word(2'b10, bus.in_ch_a);
              go_next    = 1'b1;
              pend_next  = 1'b0;
              state_next = WAIT;
            end
            2'b10: begin  // B only: latch B and buffer together
              data_next  = mk_word(2'b00, bus.in_ch_b);
              go_next    = 1'b1;
              pend_next  = 1'b0;
              state_next = WAIT;
            end
            2'b11: begin  // B into buffer first, then A loads both outputs
              data_next      = mk_word(2'b01, bus.in_ch_b);
              pend_word_next = mk_word(2'b10, bus.in_ch_a);
              pend_next      = 1'b1;
              go_next        = 1'b1;
              state_next     = WAIT;
            end
            default: ;    // no-op request is consumed silently
          endcase
        end
      end
      WAIT: begin
        if (bus.drv_set_done) begin
          gap_cnt_next = 8'(CS_GAP);
          state_next   = GAP;
        end
`ifdef TLV5618_CTRL_TIMEOUT_EN
        // Fires so that err_timeout is high in WAIT cycle TIMEOUT_CYCLES
        else if (tmo_cnt_reg == 16'(TIMEOUT_CYCLES - 2)) begin
          err_next     = 1'b1;
          pend_next    = 1'b0;
          abort_next   = 1'b1;
          gap_cnt_next = 8'(CS_GAP);
          state_next   = GAP;
        end
`endif
      end
      GAP: begin
        if (gap_cnt_reg == 8'd1) begin
          if (pend_reg) begin
            data_next  = pend_word_reg;
            go_next    = 1'b1;
            pend_next  = 1'b0;
            state_next = WAIT;
          end else begin
            done_next  = ~abort_reg;
            state_next = IDLE;
          end
        end else begin
          gap_cnt_next = gap_cnt_reg - 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
    // Ready only once IDLE has lasted a full cycle and nothing was accepted
    ready_next = (state_reg == IDLE) && (state_next == IDLE);
  end

  // State and registered outputs; reset clears everything at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      gap_cnt_reg   <= 8'd0;
      pend_reg      <= 1'b0;
      pend_word_reg <= 16'h0000;
      abort_reg     <= 1'b0;
      data_reg      <= 16'h0000;
      go_reg        <= 1'b0;
      done_reg      <= 1'b0;
      ready_reg     <= 1'b0;
`ifdef TLV5618_CTRL_TIMEOUT_EN
      tmo_cnt_reg   <= 16'd0;
      err_reg       <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      gap_cnt_reg   <= gap_cnt_next;
      pend_reg      <= pend_next;
      pend_word_reg <= pend_word_next;
      abort_reg     <= abort_next;
      data_reg      <= data_next;
      go_reg        <= go_next;
      done_reg      <= done_next;
      ready_reg     <= ready_next;
`ifdef TLV5618_CTRL_TIMEOUT_EN
      tmo_cnt_reg   <= tmo_cnt_next;
      err_reg       <= err_next;
`endif
    end
  end

  assign bus.in_ready     = ready_reg;
  assign bus.drv_set_data = data_reg;
  assign bus.drv_set_go   = go_reg;
  assign bus.upd_done     = done_reg;
  assign bus.busy         = (state_reg != IDLE);
`ifdef TLV5618_CTRL_TIMEOUT_EN
  assign bus.err_timeout  = err_reg;
`else
  assign bus.err_timeout  = 1'b0;
`endif

endmodule

// File: doc/tlv5618_ctrl.md
# tlv5618_ctrl

Upstream command sequencer for the TLV5618 serial DAC driver. Accepts dual-channel 12-bit update requests over a valid/ready handshake and builds the 16-bit TLV5618 control words, including the two-word buffered sequence for simultaneous A/B update. Issues one `set_go` per word to the downstream `tlv5618_driver` and waits for its `set_done`, enforcing a chip-select idle gap between frames. Sits between application logic (waveform/setpoint sources) and `tlv5618_driver`.

## Interface
- `SPD`, 1: speed bit D14 placed in every word (1 = fast mode).
- `PWR`, 0: power-down bit D13 placed in every word (1 = power down).
- `CS_GAP`, 4: idle clk cycles after each `drv_set_done` before the next `drv_set_go` or return to IDLE; legal range 1..255.
- `TIMEOUT_CYCLES`, 1024: max clk cycles waiting for `drv_set_done` (only with timeout macro); legal range 2..65535.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  block can accept a request.
- `in_sel`  in  2  01 = A only, 10 = B only, 11 = A and B simultaneous, 00 = no-op.
- `in_ch_a`  in  12  channel A code.
- `in_ch_b`  in  12  channel B code.
- `drv_set_data`  out  16  word to driver.
- `drv_set_go`  out  1  one-cycle start pulse to driver.
- `drv_set_done`  in  1  one-cycle completion pulse from driver.
- `upd_done`  out  1  one-cycle pulse: request fully written.
- `err_timeout`  out  1  one-cycle pulse: driver did not complete.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- Word format {R1, SPD, PWR, R0, code[11:0]}.
- B only: one word, R1R0 = 00 (write latch B and double buffer).
- A only: one word, R1R0 = 10 (write latch A, load B from buffer). Buffer always equals current B because every B write passes through it, so B output is unchanged.
- Both: word 1 = B with R1R0 = 01 (buffer only); word 2 = A with R1R0 = 10; both outputs change together.
- `in_ch_a`, `in_ch_b`, `in_sel` are captured at the accept edge; later input changes have no effect.
- States: IDLE, WAIT, GAP.
  - IDLE: `in_ready` = 1. On `in_valid` with `in_sel` != 00: register first word into `drv_set_data`, assert `drv_set_go` next cycle, go WAIT. On `in_sel` = 00: request consumed, no driver traffic, no `upd_done`, stay IDLE.
  - WAIT: `drv_set_go` low after its single cycle. On `drv_set_done`: go GAP, load gap counter.
  - GAP: count `CS_GAP` cycles; then, if a second word is pending, issue it (`drv_set_go` pulse) and go WAIT; else pulse `upd_done` and go IDLE.
- `drv_set_done` outside WAIT is ignored.
- `drv_set_data` holds its last word between frames.

## Timing
- Reset values: `in_ready` 0 during reset, 1 in the first cycle after release (IDLE). `drv_set_data` 16'h0000. `drv_set_go` 0. `upd_done` 0. `err_timeout` 0. `busy` 0. State IDLE. Counters 0.
- Accept at edge k: `drv_set_go` and the new `drv_set_data` are valid in cycle k+1, and `in_ready` is 0 from cycle k+1.
- `drv_set_done` at edge d: the next `drv_set_go` is high in cycle d+CS_GAP+1. For the final word, `upd_done` is high in cycle d+CS_GAP+1, and `in_ready` is 1 in cycle d+CS_GAP+2.
- With the driver at 50 MHz / 12.5 MHz, one frame is 68 clk cycles from go to done. A dual-channel update with CS_GAP = 4 completes in 2*(68+1+4) cycles.
- Reset mid-operation: all outputs return to reset values at once. The partial request is dropped and no pulse is emitted.

## Configuration
- `TLV5618_CTRL_TIMEOUT_EN` defined: a 16-bit counter runs in WAIT. If it reaches `TIMEOUT_CYCLES` without `drv_set_done`, the block pulses `err_timeout` for one cycle, drops any pending second word, goes to GAP, then returns to IDLE without `upd_done`.
- Undefined: WAIT waits indefinitely, `err_timeout` is tied to 0, and no counter is built.

## Test plan
- Reset, then `in_sel`=10, B=12'hABC -> one `drv_set_go` carrying 16'h4ABC (SPD=1, PWR=0); `upd_done` fires CS_GAP+1 cycles after `drv_set_done`.
- `in_sel`=11, A=12'h123, B=12'h800 -> words 16'h5800 then 16'hC123, separated by ≥CS_GAP idle cycles; exactly one `upd_done`.
- `in_valid` held high with a changing `in_ch_a` during a transfer -> `in_ready` stays 0; the next request is accepted only after `upd_done`; words use the captured values.
- `in_sel`=00 -> no `drv_set_go`, no `upd_done`; `in_ready` stays 1.
- With `TLV5618_CTRL_TIMEOUT_EN` and TIMEOUT_CYCLES=16, the model never returns done on a dual request -> `err_timeout` pulses at cycle 16 of WAIT, the second word is not issued, and the block returns to IDLE.
- Assert `rst_n` low in the middle of WAIT -> all outputs reach their reset values asynchronously, and a fresh request after release behaves normally.
